adder_arbiter: RTL and testbench

- Shares one fixed-point `adder` instance among N_REQ requesters.
- Uses round-robin arbitration with a per-requester req/ack handshake.
- Granted operands are registered, summed by the shared adder, and returned with a valid strobe and the requester id.
- Sits between multiple datapath lanes and a single adder, trading adder area for throughput (one add per cycle total).

---
 rtl/adder_arbiter_pkg.sv | 23 ++
 rtl/adder.sv | 38 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/adder_arbiter.sv | 91 +++++++++
 tb/tb_adder_arbiter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/adder_arbiter_pkg.sv
// rtl/adder_arbiter_pkg.sv - shared constants and helpers for the adder arbiter
package adder_arbiter_pkg;

  localparam int DEF_N_REQ = 4;

  // Fixed-point formats as (N_BITS, BIN_PT, SIGNED) triples
  localparam int FMT_A_N_BITS   = 3;
  localparam int FMT_A_BIN_PT   = 1;
  localparam int FMT_A_SIGNED   = 1;
  localparam int FMT_B_N_BITS   = 4;
  localparam int FMT_B_BIN_PT   = 3;
  localparam int FMT_B_SIGNED   = 0;
  localparam int FMT_OUT_N_BITS = 6;
  localparam int FMT_OUT_BIN_PT = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - fixed-point adder: aligns binary points, extends, wraps to output format
module adder #(
  parameter int N_BITS_A   = 3,
  parameter int BIN_PT_A   = 1,
  parameter int SIGNED_A   = 1,
  parameter int N_BITS_B   = 4,
  parameter int BIN_PT_B   = 3,
  parameter int SIGNED_B   = 0,
  parameter int N_BITS_OUT = 6,
  parameter int BIN_PT_OUT = 3
) (
  input  logic [N_BITS_A-1:0]   a,
  input  logic [N_BITS_B-1:0]   b,
  output logic [N_BITS_OUT-1:0] sum
);

  localparam int BP_IN  = (BIN_PT_A > BIN_PT_B) ? BIN_PT_A : BIN_PT_B;
  localparam int BP     = (BP_IN > BIN_PT_OUT) ? BP_IN : BIN_PT_OUT;
  localparam int WI     = N_BITS_A + N_BITS_B + N_BITS_OUT + BP + 2;
  localparam int SH_A   = BP - BIN_PT_A;
  localparam int SH_B   = BP - BIN_PT_B;
  localparam int SH_OUT = BP - BIN_PT_OUT;

  logic [WI-1:0] a_ext;
  logic [WI-1:0] b_ext;
  logic [WI-1:0] total;

  always_comb begin
    if (SIGNED_A != 0) a_ext = WI'($signed(a));
    else               a_ext = WI'(a);
    if (SIGNED_B != 0) b_ext = WI'($signed(b));
    else               b_ext = WI'(b);
    total = (a_ext << SH_A) + (b_ext << SH_B);
    // Extra fractional bits are truncated toward -inf; integer overflow wraps
    sum = N_BITS_OUT'($signed(total) >>> SH_OUT);
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with internal rotating priority pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  logic [ID_W-1:0] ptr;
  logic            found;
  logic [ID_W-1:0] pick;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = ID_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    grant_valid = found && !rst;
    grant_idx   = pick;
    grant       = '0;
    if (grant_valid) grant[pick] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (pick == ID_W'(N_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - shares one fixed-point adder among N_REQ round-robin requesters
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ID_W       = clog2(N_REQ),
  parameter int N_BITS_A   = FMT_A_N_BITS,
  parameter int BIN_PT_A   = FMT_A_BIN_PT,
  parameter int SIGNED_A   = FMT_A_SIGNED,
  parameter int N_BITS_B   = FMT_B_N_BITS,
  parameter int BIN_PT_B   = FMT_B_BIN_PT,
  parameter int SIGNED_B   = FMT_B_SIGNED,
  parameter int N_BITS_OUT = FMT_OUT_N_BITS,
  parameter int BIN_PT_OUT = FMT_OUT_BIN_PT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*N_BITS_A-1:0] a_in,
  input  logic [N_REQ*N_BITS_B-1:0] b_in,
  output logic [N_REQ-1:0]          ack,
  output logic [N_BITS_OUT-1:0]     sum_out,
  output logic                      sum_valid,
  output logic [ID_W-1:0]           sum_id
);

  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic [N_BITS_A-1:0]   a1;
  logic [N_BITS_B-1:0]   b1;
  logic [ID_W-1:0]       id1;
  logic                  v1;
  logic [N_BITS_OUT-1:0] sum_comb;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (ack),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Operand register; payload holds when idle since v1 qualifies it
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      id1 <= '0;
      a1  <= '0;
      b1  <= '0;
    end else begin
      v1 <= grant_valid;
      if (grant_valid) begin
        id1 <= grant_idx;
        a1  <= a_in[int'(grant_idx)*N_BITS_A +: N_BITS_A];
        b1  <= b_in[int'(grant_idx)*N_BITS_B +: N_BITS_B];
      end
    end
  end

  adder #(
    .N_BITS_A   (N_BITS_A),
    .BIN_PT_A   (BIN_PT_A),
    .SIGNED_A   (SIGNED_A),
    .N_BITS_B   (N_BITS_B),
    .BIN_PT_B   (BIN_PT_B),
    .SIGNED_B   (SIGNED_B),
    .N_BITS_OUT (N_BITS_OUT),
    .BIN_PT_OUT (BIN_PT_OUT)
  ) u_adder (
    .a   (a1),
    .b   (b1),
    .sum (sum_comb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_out   <= '0;
      sum_id    <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_out   <= sum_comb;
      sum_id    <= id1;
      sum_valid <= v1;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] a_in;
  logic [15:0] b_in;
  logic [3:0]  ack;
  logic [5:0]  sum_out;
  logic        sum_valid;
  logic [1:0]  sum_id;

  int checks = 0;
  int errors = 0;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .ack       (ack),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_id    (sum_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [2:0] a, input logic [3:0] b);
    a_in[i*3 +: 3] = a;
    b_in[i*4 +: 4] = b;
  endtask

  logic [5:0] full_sum [4];
  logic [3:0] oh;

  initial begin
    rst  = 1'b1;
    req  = 4'b1111;
    a_in = '0;
    b_in = '0;

    // Reset held two cycles with every line requesting
    #1;
    check("rst_ack_pre", 32'(ack), 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_ack", 32'(ack), 32'h0);
      check("rst_valid", 32'(sum_valid), 32'h0);
      check("rst_sum", 32'(sum_out), 32'h0);
      check("rst_id", 32'(sum_id), 32'h0);
    end
    rst = 1'b0;
    #1;
    check("first_grant", 32'(ack), 32'b0001);
    req = 4'b0000;
    step();
    step();

    // Single requester 2: -1/2 + 1/8 = -3/8
    set_ops(2, 3'b111, 4'b0001);
    req = 4'b0100;
    #1;
    check("single_ack", 32'(ack), 32'b0100);
    step();
    req = 4'b0000;
    #1;
    check("single_ack_off", 32'(ack), 32'h0);
    check("single_lat1", 32'(sum_valid), 32'h0);
    step();
    check("single_valid", 32'(sum_valid), 32'h1);
    check("single_id", 32'(sum_id), 32'd2);
    check("single_sum", 32'(sum_out), 32'b111101);
    step();
    check("single_done", 32'(sum_valid), 32'h0);

    // Arithmetic corners back-to-back through requester 3
    req = 4'b1000;
    set_ops(3, 3'b001, 4'b1000);
    #1;
    check("ar_ack0", 32'(ack), 32'b1000);
    step();
    set_ops(3, 3'b110, 4'b0100);
    #1;
    check("ar_ack1", 32'(ack), 32'b1000);
    step();
    check("ar_v0", 32'(sum_valid), 32'h1);
    check("ar_sum0", 32'(sum_out), 32'b001100);
    set_ops(3, 3'b000, 4'b0001);
    step();
    req = 4'b0000;
    check("ar_id1", 32'(sum_id), 32'd3);
    check("ar_sum1", 32'(sum_out), 32'b111100);
    step();
    check("ar_sum2", 32'(sum_out), 32'b000001);
    step();
    check("ar_done", 32'(sum_valid), 32'h0);

    // Full contention: operand a=i (i/2), b=1/8 -> sums 1,5,9,13 eighths
    for (int i = 0; i < 4; i++) set_ops(i, 3'(i), 4'b0001);
    full_sum[0] = 6'd1;
    full_sum[1] = 6'd5;
    full_sum[2] = 6'd9;
    full_sum[3] = 6'd13;
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      oh = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      check("full_ack", 32'(ack), 32'(oh));
      check("full_valid", 32'(sum_valid), (c >= 2) ? 32'h1 : 32'h0);
      if (c >= 2) begin
        check("full_id", 32'(sum_id), 32'((c - 2) % 4));
        check("full_sum", 32'(sum_out), 32'(full_sum[(c - 2) % 4]));
      end
      step();
    end
    check("full_drain", 32'(sum_valid), 32'h0);

    // Skip and wrap: grant 1, then req 1010 -> 3, 1, 3
    req = 4'b0010;
    #1;
    check("skip_ack1", 32'(ack), 32'b0010);
    step();
    req = 4'b1010;
    #1;
    check("skip_ack3a", 32'(ack), 32'b1000);
    step();
    check("skip_ack1b", 32'(ack), 32'b0010);
    check("skip_id1", 32'(sum_id), 32'd1);
    step();
    check("skip_ack3b", 32'(ack), 32'b1000);
    check("skip_id3", 32'(sum_id), 32'd3);
    step();
    req = 4'b0000;
    step();
    step();

    // Mid-operation reset with results for 0 and 1 in flight
    req = 4'b1111;
    #1;
    check("mid_ack0", 32'(ack), 32'b0001);
    step();
    check("mid_ack1", 32'(ack), 32'b0010);
    step();
    check("mid_id0", 32'(sum_id), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack), 32'h0);
    step();
    check("mid_rst_valid", 32'(sum_valid), 32'h0);
    rst = 1'b0;
    #1;
    check("mid_ptr0", 32'(ack), 32'b0001);
    check("mid_drop", 32'(sum_valid), 32'h0);
    step();
    req = 4'b0000;
    #1;
    check("mid_drop2", 32'(sum_valid), 32'h0);
    step();
    check("mid_new_valid", 32'(sum_valid), 32'h1);
    check("mid_new_id", 32'(sum_id), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
